id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath width.
REQ-002 The block SHALL have parameter REGW, default 5, register-index width.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have ports id_valid (1), id_rs1_data/id_rs2_data/id_imm (XLEN), id_rs1/id_rs2/id_rd (REGW), id_ex_cmd (4), id_alu_src (1, 1=use imm), id_reg_write, id_mem_read, id_mem_write (1 each), all inputs from decode.
REQ-006 The block SHALL have inputs stall (1, hold stage) and flush (1, kill stage contents).
REQ-007 The block SHALL have forwarding inputs exmem_reg_write (1), exmem_rd (REGW), exmem_result (XLEN), memwb_reg_write (1), memwb_rd (REGW), memwb_result (XLEN).
REQ-008 The block SHALL have outputs ex_valid (1), alu_in1/alu_in2/ex_store_data (XLEN), ex_cmd (4), ex_rd (REGW), ex_reg_write, ex_mem_read, ex_mem_write (1 each), load_use_hazard (1).

Function
REQ-009 On each rising edge with flush=0 and stall=0, the stage registers SHALL capture all id_* fields; latency decode->ALU operands is one cycle.
REQ-010 With stall=1 and flush=0, all stage registers SHALL hold their values.
REQ-011 With flush=1 (regardless of stall), the stage SHALL load a bubble: valid=0, reg_write=0, mem_read=0, mem_write=0, cmd=ADD, rd=0; data registers don't-care but cleared to 0.
REQ-012 A captured entry with id_valid=0 SHALL behave as a bubble (control bits forced 0).
REQ-013 Forwarded operand A SHALL be: exmem_result if exmem_reg_write=1, exmem_rd!=0, exmem_rd==stored rs1; else memwb_result if same test against memwb; else stored rs1 data.
REQ-014 Forwarded operand B SHALL use the identical rule against stored rs2; EX/MEM has priority over MEM/WB when both match.
REQ-015 Register index 0 SHALL never be forwarded.
REQ-016 alu_in1 SHALL equal forwarded A; alu_in2 SHALL equal stored imm when stored alu_src=1, else forwarded B.
REQ-017 ex_store_data SHALL always equal forwarded B, independent of alu_src.
REQ-018 Forwarding and operand selection SHALL be combinational from stage registers and forwarding inputs (same-cycle).
REQ-019 load_use_hazard SHALL be 1 when ex_valid=1, ex_mem_read=1, ex_rd!=0 and ex_rd equals id_rs1 or id_rs2, with id_valid=1; else 0.
REQ-020 load_use_hazard SHALL NOT be gated by stall or flush; hazard unit decides.
REQ-021 Outputs ex_cmd, ex_rd and control bits SHALL be direct register outputs.

Reset
REQ-022 rst_n=0 SHALL asynchronously clear every stage register to the bubble value of REQ-011, including mid-stall.
REQ-023 After reset release, ex_valid=0, load_use_hazard=0 and alu_in1=alu_in2=0 until first capture (with idle forwarding inputs).

Structure
REQ-024 ALU command encodings (ADD 0000, SUB 0001, AND 0010, OR 0011, NOR 0100, XOR 0101, SLL 0110, SLA 0111, SRL 1000, SRA 1001), the bubble command, and forward-select enum (REG, EXMEM, MEMWB) SHALL live in a shared processor package.
REQ-025 Forwarding selection SHALL be one sub-module fwd_mux, instantiated twice (A and B).

Verification
REQ-026 Capture: id_rs1_data=5, id_rs2_data=7, cmd=ADD, no forwarding -> next cycle alu_in1=5, alu_in2=7, ex_cmd=0000, ex_valid=1.
REQ-027 Priority: stored rs1=3, exmem_rd=3 result 0xAAAA, memwb_rd=3 result 0xBBBB, both write -> alu_in1=0xAAAA; drop exmem_reg_write -> 0xBBBB.
REQ-028 r0: stored rs2=0, exmem_rd=0 result 0x1234 write=1, alu_src=0 -> alu_in2=stored rs2 data, not 0x1234.
REQ-029 Stall/flush: stall=1 two cycles while id_* changes -> outputs unchanged; stall=1 and flush=1 together -> ex_valid=0, ex_reg_write=0, ex_cmd=ADD.
REQ-030 Load-use: ex holds load, rd=4; decode id_rs2=4, id_valid=1 -> load_use_hazard=1; id_rs2=0 with ex_rd=0 -> 0.
REQ-031 Async reset: assert rst_n=0 mid-cycle with valid entry -> ex_valid, ex_reg_write drop immediately without clock edge.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared processor definitions: ALU command encodings, the bubble command and
// the operand forwarding-source select used by the ID/EX stage.
package id_ex_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_NOR = 4'b0100,
    ALU_XOR = 4'b0101,
    ALU_SLL = 4'b0110,
    ALU_SLA = 4'b0111,
    ALU_SRL = 4'b1000,
    ALU_SRA = 4'b1001
  } alu_cmd_e;

  // An ADD on a killed entry is harmless because nothing downstream commits it.
  localparam alu_cmd_e BUBBLE_CMD = ALU_ADD;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux: picks the youngest in-flight result that targets the
// stored source register, falling back to the register-file value.
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] rs,
  input  logic [XLEN-1:0] reg_data,
  input  logic            exmem_reg_write,
  input  logic [REGW-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [REGW-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] data
);

  fwd_sel_e sel;
  logic     exmem_hit;
  logic     memwb_hit;

  // r0 is hard-wired zero, so a pending write to it must never be forwarded.
  assign exmem_hit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs);
  assign memwb_hit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs);

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    sel = FWD_REG;
    if (exmem_hit)      sel = FWD_EXMEM;
    else if (memwb_hit) sel = FWD_MEMWB;
  end

  always_comb begin
    data = reg_data;
    case (sel)
      FWD_EXMEM: data = exmem_result;
      FWD_MEMWB: data = memwb_result;
      default:   data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, ALU operand selection and
// load-use hazard detection against the instruction currently in decode.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic [3:0]      id_ex_cmd,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            stall,
  input  logic            flush,
  input  logic            exmem_reg_write,
  input  logic [REGW-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [REGW-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic            ex_valid,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [XLEN-1:0] ex_store_data,
  output logic [3:0]      ex_cmd,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            load_use_hazard
);

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            alu_src;
    alu_cmd_e        cmd;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
  } stage_t;

  function automatic stage_t bubble();
    stage_t b;
    b     = '0;
    b.cmd = BUBBLE_CMD;
    return b;
  endfunction

  stage_t          stage_q;
  stage_t          stage_d;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  // Flush wins over stall; an invalid decode slot is captured as a bubble.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = bubble();
    end else if (!stall) begin
      stage_d.valid     = id_valid;
      stage_d.reg_write = id_valid & id_reg_write;
      stage_d.mem_read  = id_valid & id_mem_read;
      stage_d.mem_write = id_valid & id_mem_write;
      stage_d.alu_src   = id_alu_src;
      stage_d.cmd       = alu_cmd_e'(id_ex_cmd);
      stage_d.rs1       = id_rs1;
      stage_d.rs2       = id_rs2;
      stage_d.rd        = id_rd;
      stage_d.rs1_data  = id_rs1_data;
      stage_d.rs2_data  = id_rs2_data;
      stage_d.imm       = id_imm;
    end
  end

  // NOTE: every field is a flop (no RAM), so the whole stage is cleared on reset
  // and state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= bubble();
    else        stage_q <= stage_d;
  end

  fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_a (
    .rs              (stage_q.rs1),
    .reg_data        (stage_q.rs1_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .data            (fwd_a)
  );

  fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_b (
    .rs              (stage_q.rs2),
    .reg_data        (stage_q.rs2_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .data            (fwd_b)
  );

  assign alu_in1       = fwd_a;
  assign alu_in2       = stage_q.alu_src ? stage_q.imm : fwd_b;
  assign ex_store_data = fwd_b;

  assign ex_valid      = stage_q.valid;
  assign ex_cmd        = stage_q.cmd;
  assign ex_rd         = stage_q.rd;
  assign ex_reg_write  = stage_q.reg_write;
  assign ex_mem_read   = stage_q.mem_read;
  assign ex_mem_write  = stage_q.mem_write;

  // Raw hazard report; the hazard unit decides whether to stall or flush.
  assign load_use_hazard = stage_q.valid && stage_q.mem_read && (stage_q.rd != '0)
                           && id_valid && ((stage_q.rd == id_rs1) || (stage_q.rd == id_rs2));

endmodule
